// File: rtl/pio_cmd_responder.sv
// HPS PIO command endpoint: four-phase instruct/enable handshake driving a local byte memory.
// Optional CHECKSUM opcode and SUM state are compiled in when PIO_RESP_CHECKSUM_EN is defined.
module pio_cmd_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [28:0] pio_instruct,
  input  logic        pio_enable,
  output logic [7:0]  pio_data_out,
  output logic [3:0]  pio_flags
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpWrite = 3'd1;
  localparam logic [2:0] OpRead  = 3'd2;
  localparam logic [2:0] OpClear = 3'd3;
  localparam logic [2:0] OpSum   = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRdWait,
    StClear,
    StSum,
    StDone
  } state_t;

  state_t              r_state;
  logic [28:0]         r_instr;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_err;
  logic [7:0]          r_result;
  logic                r_load;
  logic                r_done;
  logic                r_busy;
  logic                r_error;
  logic [7:0]          r_data_out;
  logic [7:0]          r_rdata;
  logic [7:0]          r_mem [Depth];
`ifdef PIO_RESP_CHECKSUM_EN
  logic [7:0]          r_acc;
  logic                r_sum_vld;
  logic                r_rd_last;
`endif

  logic [2:0]          w_op;
  logic [17:0]         w_addr;
  logic [7:0]          w_wdata;
  logic                w_addr_oob;
  logic                w_op_illegal;
  logic                w_err;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_mem_we;
  logic [7:0]          w_mem_wdata;

  assign w_op       = r_instr[2:0];
  assign w_addr     = r_instr[20:3];
  assign w_wdata    = r_instr[28:21];
  assign w_addr_oob = (w_addr >> ADDR_W) != '0;

`ifdef PIO_RESP_CHECKSUM_EN
  assign w_op_illegal = (w_op > OpSum);
`else
  assign w_op_illegal = (w_op >= OpSum);
`endif

  assign w_err = w_op_illegal || (((w_op == OpWrite) || (w_op == OpRead)) && w_addr_oob);

  always_comb begin
    w_mem_addr  = w_addr[ADDR_W-1:0];
    w_mem_we    = 1'b0;
    w_mem_wdata = w_wdata;
    case (r_state)
      StDecode: w_mem_we = (w_op == OpWrite) && !w_err;
      StClear: begin
        w_mem_addr  = r_cnt;
        w_mem_we    = 1'b1;
        w_mem_wdata = 8'h00;
      end
      StSum:    w_mem_addr = r_cnt;
      default:  ;
    endcase
  end

  // Single-port synchronous RAM, contents deliberately not reset.
  always_ff @(posedge clk_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
    r_rdata <= r_mem[w_mem_addr];
  end

  // Flags and data output are registered one edge behind the state they describe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= StIdle;
      r_instr    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_result   <= 8'h00;
      r_load     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_data_out <= 8'h00;
`ifdef PIO_RESP_CHECKSUM_EN
      r_acc      <= 8'h00;
      r_sum_vld  <= 1'b0;
      r_rd_last  <= 1'b0;
`endif
    end else begin
      r_done  <= (r_state == StDone);
      r_busy  <= (r_state == StDecode) || (r_state == StRdWait) ||
                 (r_state == StClear)  || (r_state == StSum);
      r_error <= r_err;
      if ((r_state == StDone) && r_load) begin
        r_data_out <= r_result;
        r_load     <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (pio_enable) begin
            r_instr <= pio_instruct;
            r_err   <= 1'b0;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          r_cnt <= '0;
`ifdef PIO_RESP_CHECKSUM_EN
          r_acc     <= 8'h00;
          r_sum_vld <= 1'b0;
          r_rd_last <= 1'b0;
`endif
          if (w_err) begin
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            case (w_op)
              OpRead:  r_state <= StRdWait;
              OpClear: r_state <= StClear;
`ifdef PIO_RESP_CHECKSUM_EN
              OpSum:   r_state <= StSum;
`endif
              default: r_state <= StDone;
            endcase
          end
        end
        StRdWait: begin
          r_result <= r_rdata;
          r_load   <= 1'b1;
          r_state  <= StDone;
        end
        StClear: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= StDone;
          end
        end
`ifdef PIO_RESP_CHECKSUM_EN
        StSum: begin
          // r_rdata holds the byte addressed on the previous edge once r_sum_vld is set.
          if (r_sum_vld) begin
            r_acc <= r_acc + r_rdata;
          end
          r_sum_vld <= 1'b1;
          if (r_rd_last) begin
            r_result <= r_acc + r_rdata;
            r_load   <= 1'b1;
            r_state  <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
              r_rd_last <= 1'b1;
            end
          end
        end
`endif
        StDone: begin
          if (!pio_enable) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign pio_data_out = r_data_out;
  assign pio_flags    = {(r_data_out == 8'h00), r_error, r_busy, r_done};

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Directed table-driven bench for pio_cmd_responder at ADDR_W=4, plus handshake corner sequences.
module tb_pio_cmd_responder;

  logic        clk;
  logic        rst_n;
  logic [28:0] instr;
  logic        en;
  logic [7:0]  dout;
  logic [3:0]  flags;

  int n_cmp  = 0;
  int n_fail = 0;

  pio_cmd_responder #(.ADDR_W(4)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .pio_instruct (instr),
    .pio_enable   (en),
    .pio_data_out (dout),
    .pio_flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [17:0] addr;
    logic [7:0]  data;
    int          e_edge;
    int          e_busy;
    logic [3:0]  e_flags;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [17:0] addr, input logic [7:0] data,
                              input int e_edge, input int e_busy, input logic [3:0] e_flags,
                              input logic [7:0] e_dout);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data;
    v.e_edge = e_edge; v.e_busy = e_busy; v.e_flags = e_flags; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Raise enable with the instruction, count edges from acceptance (edge 0) until DONE.
  task automatic run_txn(input logic [2:0] op, input logic [17:0] addr, input logic [7:0] data,
                         input bit drop_early, output int done_edge, output int busy_n);
    @(negedge clk);
    instr = {data, addr, op};
    en    = 1'b1;
    done_edge = -1;
    busy_n    = 0;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk);
      #1;
      if (drop_early && e == 1) en = 1'b0;
      if (flags[1]) busy_n++;
      if (flags[0]) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic finish_txn(input string nm);
    int fall_at;
    @(negedge clk);
    en = 1'b0;
    fall_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!flags[0]) begin
        fall_at = i;
        break;
      end
    end
    chk({nm, " done_fall"}, fall_at, 1);
  endtask

  task automatic check_txn(input vec_t v, input string nm);
    int de, bn;
    run_txn(v.op, v.addr, v.data, 1'b0, de, bn);
    chk({nm, " done_edge"}, de, v.e_edge);
    chk({nm, " busy_cycles"}, bn, v.e_busy);
    chk({nm, " flags"}, int'(flags), int'(v.e_flags));
    chk({nm, " data_out"}, int'(dout), int'(v.e_dout));
    finish_txn(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int de, bn;
    rst_n = 1'b0;
    en    = 1'b0;
    instr = '0;
    #1;
    chk("reset flags", int'(flags), 4'b1000);
    chk("reset data_out", int'(dout), 8'h00);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    //          op    addr       data   edge busy flags    dout
    vecs.push_back(mk(3'd1, 18'd5,     8'hA7, 2, 1, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd2, 18'd5,     8'h00, 3, 2, 4'b0001, 8'hA7));
    vecs.push_back(mk(3'd1, 18'd0,     8'h44, 2, 1, 4'b0001, 8'hA7));
    vecs.push_back(mk(3'd1, 18'h20,    8'h11, 2, 1, 4'b0101, 8'hA7));
    vecs.push_back(mk(3'd2, 18'd0,     8'h00, 3, 2, 4'b0001, 8'h44));
    vecs.push_back(mk(3'd2, 18'h10,    8'h00, 2, 1, 4'b0101, 8'h44));
    vecs.push_back(mk(3'd7, 18'd0,     8'h00, 2, 1, 4'b0101, 8'h44));
    vecs.push_back(mk(3'd0, 18'h3FFFF, 8'hFF, 2, 1, 4'b0001, 8'h44));
    vecs.push_back(mk(3'd1, 18'd15,    8'h5C, 2, 1, 4'b0001, 8'h44));
    vecs.push_back(mk(3'd2, 18'd15,    8'h00, 3, 2, 4'b0001, 8'h5C));
    vecs.push_back(mk(3'd1, 18'd3,     8'h00, 2, 1, 4'b0001, 8'h5C));
    vecs.push_back(mk(3'd2, 18'd3,     8'h00, 3, 2, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd2, 18'd15,    8'h00, 3, 2, 4'b0001, 8'h5C));
    vecs.push_back(mk(3'd3, 18'd0,     8'h00, 18, 17, 4'b0001, 8'h5C));
    vecs.push_back(mk(3'd2, 18'd15,    8'h00, 3, 2, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd2, 18'd5,     8'h00, 3, 2, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd2, 18'h20000, 8'h00, 2, 1, 4'b1101, 8'h00));
`ifdef PIO_RESP_CHECKSUM_EN
    vecs.push_back(mk(3'd3, 18'd0,     8'h00, 18, 17, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd1, 18'd0,     8'hFF, 2, 1, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd1, 18'd9,     8'h03, 2, 1, 4'b1001, 8'h00));
    vecs.push_back(mk(3'd4, 18'd0,     8'h00, 19, 18, 4'b0001, 8'h02));
    vecs.push_back(mk(3'd2, 18'd0,     8'h00, 3, 2, 4'b0001, 8'hFF));
    vecs.push_back(mk(3'd3, 18'd0,     8'h00, 18, 17, 4'b0001, 8'hFF));
    vecs.push_back(mk(3'd2, 18'd1,     8'h00, 3, 2, 4'b1001, 8'h00));
`else
    vecs.push_back(mk(3'd4, 18'd0,     8'h00, 2, 1, 4'b1101, 8'h00));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      check_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Enable dropped after edge 1 of a READ: DONE pulses for one cycle only.
    check_txn(mk(3'd1, 18'd6, 8'h6E, 2, 1, 4'b1001, 8'h00), "early_wr");
    run_txn(3'd2, 18'd6, 8'h00, 1'b1, de, bn);
    chk("early done_edge", de, 3);
    chk("early flags", int'(flags), 4'b0001);
    chk("early data_out", int'(dout), 8'h6E);
    @(posedge clk);
    #1;
    chk("early done_pulse", int'(flags[0]), 0);
    check_txn(mk(3'd0, 18'd0, 8'h00, 2, 1, 4'b0001, 8'h6E), "early_next");

    // Enable held high after DONE: stays done, never goes busy again.
    run_txn(3'd1, 18'd8, 8'h88, 1'b0, de, bn);
    chk("hold done_edge", de, 2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold cyc%0d done_busy", i), int'(flags[1:0]), 2'b01);
    end
    finish_txn("hold");
    check_txn(mk(3'd2, 18'd8, 8'h00, 3, 2, 4'b0001, 8'h88), "hold_rd");

    // Reset mid-CLEAR: outputs reset asynchronously, memory only partially cleared.
    check_txn(mk(3'd1, 18'd7,  8'h77, 2, 1, 4'b0001, 8'h88), "rst_w7");
    check_txn(mk(3'd1, 18'd12, 8'h12, 2, 1, 4'b0001, 8'h88), "rst_w12");
    check_txn(mk(3'd2, 18'd7,  8'h00, 3, 2, 4'b0001, 8'h77), "rst_r7a");
    @(negedge clk);
    instr = {8'h00, 18'd0, 3'd3};
    en    = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("midclear busy", int'(flags[1]), 1);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("midclear rst flags", int'(flags), 4'b1000);
    chk("midclear rst data_out", int'(dout), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    check_txn(mk(3'd2, 18'd2,  8'h00, 3, 2, 4'b1001, 8'h00), "rst_r2");
    check_txn(mk(3'd2, 18'd12, 8'h00, 3, 2, 4'b0001, 8'h12), "rst_r12");
    check_txn(mk(3'd2, 18'd7,  8'h00, 3, 2, 4'b0001, 8'h77), "rst_r7b");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
